// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants and FSM state type for the PWM duty-cycle meter.
package pwm_duty_meter_pkg;

  localparam int unsigned DUTY_MAX       = 100;
  localparam int unsigned PWM_PERIOD_CYC = 2000;  // 25 kHz at 50 MHz
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned DIV_ITERS      = 7;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StDiv
  } meter_state_e;

endpackage

// File: rtl/duty_div.sv
// Fixed-latency restoring divider: 7 quotient bits, one per cycle, start/busy/done handshake.
module duty_div
  import pwm_duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [CNT_W+6:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [6:0]       quotient
);

  localparam logic [2:0] IterLast = 3'(DIV_ITERS - 1);

  logic             busy_q;
  logic [2:0]       iter_q;
  logic [CNT_W-1:0] rem_q;
  logic [6:0]       low_q;
  logic [CNT_W-1:0] dvs_q;
  logic [5:0]       quo_q;

  logic [CNT_W:0]   trial;
  logic             fits;
  logic [CNT_W-1:0] rem_nxt;
  logic [6:0]       quo_nxt;

  // Remainder stays below the divisor, so it never needs more than CNT_W bits.
  always_comb begin
    trial   = {rem_q, low_q[6]};
    fits    = (trial >= {1'b0, dvs_q});
    rem_nxt = fits ? CNT_W'(trial - {1'b0, dvs_q}) : trial[CNT_W-1:0];
    quo_nxt = {quo_q, fits};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      low_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else if (start && !busy_q) begin
      busy_q <= 1'b1;
      iter_q <= '0;
      rem_q  <= dividend[CNT_W+6:7];
      low_q  <= dividend[6:0];
      dvs_q  <= divisor;
      quo_q  <= '0;
    end else if (busy_q) begin
      rem_q  <= rem_nxt;
      low_q  <= {low_q[5:0], 1'b0};
      quo_q  <= quo_nxt[5:0];
      iter_q <= iter_q + 3'd1;
      if (iter_q == IterLast) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Last bit is resolved combinationally so the result is ready in the 7th busy cycle.
  assign busy     = busy_q;
  assign done     = busy_q && (iter_q == IterLast);
  assign quotient = quo_nxt;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and duty (percent) of an asynchronous PWM input, with loss-of-signal timeout.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic [6:0]       duty_data,
  output logic             duty_valid,
  output logic [CNT_W-1:0] period_cyc,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TimeoutSat  = CNT_W'(TIMEOUT);

  logic sync_q, pwm_s, pwm_prev;
  logic rise, any_edge, timeout_hit;

  logic [CNT_W-1:0] idle_q, per_q, high_q, per_lat_q;
  meter_state_e     state_q, state_d;

  logic             div_start, div_busy, div_done, meas_done;
  logic [CNT_W+6:0] dividend;
  logic [6:0]       div_quo, duty_clamped;

  logic [6:0]       duty_q;
  logic             valid_q, nosig_q;
  logic [CNT_W-1:0] period_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= 1'b0;
      pwm_s    <= 1'b0;
      pwm_prev <= 1'b0;
    end else begin
      sync_q   <= pwm_in;
      pwm_s    <= sync_q;
      pwm_prev <= pwm_s;
    end
  end

  assign rise        = pwm_s & ~pwm_prev;
  assign any_edge    = pwm_s ^ pwm_prev;
  // Idle counter parks at TIMEOUT after firing, so a stuck input reports only once.
  assign timeout_hit = !any_edge && (idle_q == TimeoutLast);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_q <= '0;
      per_q  <= '0;
      high_q <= '0;
    end else begin
      if (any_edge)                 idle_q <= '0;
      else if (idle_q != TimeoutSat) idle_q <= idle_q + CNT_W'(1);

      if (rise)              per_q <= CNT_W'(1);
      else if (per_q != '1)  per_q <= per_q + CNT_W'(1);

      // The edge cycle itself is high, so the high count restarts at 1.
      if (rise)                       high_q <= CNT_W'(1);
      else if (pwm_s && high_q != '1) high_q <= high_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (rise)     state_d = StArmed;
        StArmed: if (rise)     state_d = StDiv;
        StDiv:   if (div_done) state_d = StArmed;
        default:               state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    div_start = 1'b0;
    meas_done = 1'b0;
    if (!timeout_hit) begin
      div_start = (state_q == StArmed) && rise && !div_busy;
      meas_done = (state_q == StDiv) && div_done;
    end
  end

  assign dividend = (CNT_W+7)'(high_q) * (CNT_W+7)'(DUTY_MAX);

  duty_div #(
    .CNT_W (CNT_W)
  ) u_duty_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (div_start),
    .dividend  (dividend),
    .divisor   (per_q),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo)
  );

  assign duty_clamped = (div_quo > 7'(DUTY_MAX)) ? 7'(DUTY_MAX) : div_quo;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      per_lat_q <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      nosig_q   <= 1'b0;
    end else begin
      if (div_start) per_lat_q <= per_q;
      valid_q <= timeout_hit | meas_done;
      if (timeout_hit) begin
        duty_q   <= pwm_s ? 7'(DUTY_MAX) : 7'd0;
        period_q <= '0;
        nosig_q  <= 1'b1;
      end else if (meas_done) begin
        duty_q   <= duty_clamped;
        period_q <= per_lat_q;
        nosig_q  <= 1'b0;
      end
    end
  end

  assign duty_data  = duty_q;
  assign duty_valid = valid_q;
  assign period_cyc = period_q;
  assign no_signal  = nosig_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench: stimulus pushes expected duty results, a negedge monitor pops and compares.
module tb_pwm_duty_meter;
  import pwm_duty_meter_pkg::*;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 4000;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b1;
  logic             pwm_in    = 1'b0;
  logic [6:0]       duty_data;
  logic             duty_valid;
  logic [CNT_W-1:0] period_cyc;
  logic             no_signal;

  pwm_duty_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pwm_in     (pwm_in),
    .duty_data  (duty_data),
    .duty_valid (duty_valid),
    .period_cyc (period_cyc),
    .no_signal  (no_signal)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int period;
    int at_cyc;
    bit nosig;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus-side model of the meter's arming and busy window.
  bit armed       = 1'b0;
  int last_start  = -1000;
  int last_edge   = 0;
  int prev_duty   = 0;
  int prev_period = 0;
  int wave_duty   = 0;
  int wave_period = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  // Input driven at cycle n is detected as an edge at n+2; a result appears at n+10.
  task automatic drive(input logic v);
    if (pwm_in !== v) begin
      pwm_in    = v;
      last_edge = cyc;
      if (v) begin
        if (!armed) begin
          armed = 1'b1;
        end else if (cyc - last_start >= 8) begin
          sb.push_back('{prev_duty, prev_period, cyc + 10, 1'b0});
          last_start = cyc;
        end
        prev_duty   = wave_duty;
        prev_period = wave_period;
      end
    end
  endtask

  task automatic wave(input int period, input int high, input int duty, input int count);
    wave_duty   = duty;
    wave_period = period;
    repeat (count) begin
      drive(1'b1);
      tick(high);
      drive(1'b0);
      tick(period - high);
    end
  endtask

  task automatic hold_level(input logic v);
    wave_duty = -1;
    drive(v);
    sb.push_back('{(v ? 100 : 0), 0, last_edge + int'(TIMEOUT) + 3, 1'b1});
    armed = 1'b0;
    tick(last_edge + int'(TIMEOUT) + 8 - cyc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_duty_data"}, int'(duty_data), 0);
    check({tag, "_duty_valid"}, int'(duty_valid), 0);
    check({tag, "_period_cyc"}, int'(period_cyc), 0);
    check({tag, "_no_signal"}, int'(no_signal), 0);
  endtask

  always @(negedge sys_clk) begin
    if (duty_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_duty_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("duty_data", int'(duty_data), mon_e.duty);
        check("period_cyc", int'(period_cyc), mon_e.period);
        check("no_signal", int'(no_signal), mon_e.nosig);
        check("valid_cycle", cyc, mon_e.at_cyc);
      end
    end
  end

  initial begin
    #1 sys_rst_n = 1'b0;
    tick(3);
    check_zero("reset");
    sys_rst_n = 1'b1;
    tick(2);
    check_zero("post_reset");

    wave(PWM_PERIOD_CYC, 1000, 50, 3);
    wave(PWM_PERIOD_CYC, 1999, 99, 2);
    wave(PWM_PERIOD_CYC, 666, 33, 2);
    // Loop-back: generator duty d gives high = d * 20 cycles at period 2000.
    wave(PWM_PERIOD_CYC, 20, 1, 2);
    wave(PWM_PERIOD_CYC, 500, 25, 2);
    wave(PWM_PERIOD_CYC, 1500, 75, 2);
    wave(PWM_PERIOD_CYC, 1980, 99, 2);
    hold_level(1'b0);
    hold_level(1'b1);
    wave(PWM_PERIOD_CYC, 1000, 50, 3);
    wave(6, 3, 50, 6);

    // Abort a division at E+4 with reset.
    drive(1'b1);
    tick(6);
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    sb.delete();
    armed = 1'b0;
    tick(1);
    check_zero("mid_div_reset");
    tick(2);
    sys_rst_n = 1'b1;
    tick(3);
    check_zero("after_abort");
    wave(PWM_PERIOD_CYC, 1000, 50, 3);

    tick(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the period and high-time counters in sys_clk cycles.
REQ-002 Parameter TIMEOUT, default 4000, SHALL set the number of cycles without any input edge before loss of signal is declared; TIMEOUT <= 2^CNT_W-1.
REQ-003 sys_clk  input  1  system clock; all logic is on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 pwm_in  input  1  PWM signal to measure, asynchronous to sys_clk.
REQ-006 duty_data  output  7  measured duty in percent, 0-100.
REQ-007 duty_valid  output  1  one-cycle pulse when duty_data is updated.
REQ-008 period_cyc  output  CNT_W  last measured period in sys_clk cycles.
REQ-009 no_signal  output  1  high while the input is declared stuck (timeout).

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized level (pwm_s) and its previous-cycle copy.
REQ-011 Cycle E is the cycle in which the synchronized rising edge is detected; the period is measured rising edge to rising edge, and high time is measured rising edge to falling edge.
REQ-012 The period counter SHALL be 1 in cycle E+1 and SHALL increment by 1 each cycle; the high counter SHALL increment only while pwm_s=1.
REQ-013 The first rising edge after reset or timeout SHALL only arm the meter (state ARMED) and SHALL produce no output.
REQ-014 On each rising edge while armed and idle, the block SHALL latch period P and high time H, restart both counters, and start the divider.
REQ-015 duty SHALL be floor(H*100/P), computed as a 7-bit restoring division over 7 iterations at one per cycle; the result SHALL be clamped to 100.
REQ-016 duty_data and period_cyc SHALL update, and duty_valid SHALL pulse, in cycle E+8; there SHALL be no other latency.
REQ-017 A rising edge that arrives while the divider is busy (P < 8) SHALL restart the counters but SHALL NOT start a division; no output SHALL result from it.
REQ-018 Edge counters SHALL NOT wrap; because TIMEOUT fires first, saturation cannot occur.
REQ-019 If no edge of either polarity occurs for TIMEOUT consecutive cycles, the block SHALL perform all of the following: set duty_data=100 if pwm_s=1 or 0 if pwm_s=0, pulse duty_valid once, set no_signal=1, set period_cyc=0, and disarm.
REQ-020 A timeout SHALL NOT repeat while the block stays stuck; no_signal SHALL clear at the next valid duty_valid from a measurement.
REQ-021 States SHALL be IDLE (disarmed), ARMED (counting), and DIV (dividing, returns to ARMED); a timeout from any state SHALL go to IDLE.

Reset
REQ-022 On reset, all of the following SHALL be 0: duty_data, duty_valid, period_cyc, no_signal, synchronizer flops, counters, and divider registers; the FSM SHALL be in IDLE.
REQ-023 Reset asserted mid-measurement or mid-division SHALL abort it with no duty_valid; the first output after reset SHALL require two rising edges.

Structure
REQ-024 The shared package SHALL hold DUTY_MAX=100, PWM_PERIOD_CYC=2000 (25 kHz at 50 MHz), the default CNT_W, and the FSM state enumeration.
REQ-025 The division SHALL be a sub-module duty_div: start/busy/done handshake, CNT_W+7-bit dividend, CNT_W-bit divisor, 7-bit quotient, fixed 7-cycle latency.
REQ-026 The block SHALL be loop-back compatible with the existing PWM generator: a generator set to duty d SHALL measure as d.

Verification
REQ-027 Period 2000 cycles, high 1000 cycles -> second and later rising edges give duty_data=50, period_cyc=2000, duty_valid at E+8.
REQ-028 Period 2000, high 1999 -> 99 (floor); high 666 -> 33; loop-back from the PWM generator for d=0..100 -> each measurement equals d, except d=0 and d=100, which give a timeout result.
REQ-029 pwm_in held 0 for 4000+ cycles -> exactly one duty_valid with duty_data=0 and no_signal=1; held 1 -> duty_data=100 and no_signal=1; normal PWM resumes -> no_signal clears on the first measured duty.
REQ-030 Period 6 cycles, high 3 -> edges arriving during DIV are ignored, no spurious duty_valid occurs, and outputs remain consistent.
REQ-031 sys_rst_n pulsed low at cycle E+4 of a division -> no duty_valid, all outputs 0, re-arm on the next rising edge, and the first result follows the second rising edge.
